// File: rtl/pixel_writer_pkg.sv
// pixel_writer_pkg
//   Shared definitions for the pixel path: screen geometry and framebuffer
//   address width (also used by screen_refresh and the sprite drawers), the
//   pixel record, the output-stage state type, and the coordinate-to-address
//   and colour-packing helpers.
package pixel_writer_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ADDR_W   = 15;

  // One pixel as presented by an upstream producer.
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic {
    OUT_IDLE,
    OUT_WRITE
  } out_state_t;

  // Row-major linear address. The caller truncates to its address width.
  function automatic logic [31:0] xy_to_addr(input logic [7:0] x,
                                             input logic [7:0] y,
                                             input int unsigned screen_w);
    return 32'(y) * screen_w + 32'(x);
  endfunction

  // Keeps the top ch_bits of each channel and packs them as {R,G,B} in the
  // low 3*ch_bits bits of the result. No rounding: plain truncation.
  function automatic logic [23:0] pack_rgb(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b,
                                           input int unsigned ch_bits);
    logic [23:0] v_r;
    logic [23:0] v_g;
    logic [23:0] v_b;
    v_r = 24'(r) >> (8 - ch_bits);
    v_g = 24'(g) >> (8 - ch_bits);
    v_b = 24'(b) >> (8 - ch_bits);
    return (v_r << (2 * ch_bits)) | (v_g << ch_bits) | v_b;
  endfunction

endpackage

// File: rtl/pixel_writer_fifo.sv
// pixel_fifo
//   Synchronous show-ahead FIFO: the head entry is visible on o_rd_data
//   whenever o_empty is low, and i_pop advances past it. Push and pop may
//   occur in the same cycle. The caller must not push when full or pop when
//   empty.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   i_push, i_wr_data enqueue request and data
//   i_pop             dequeue the current head
//   o_rd_data         current head entry
//   o_full, o_empty   occupancy flags (registered-state only)
module pixel_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      if (i_pop)  r_rd_ptr <= r_rd_ptr + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // NOTE: storage is deliberately not reset; emptiness is carried by the
  // pointers, so stale entries are never observed and the array maps to RAM.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/pixel_writer.sv
// pixel_writer
//   Accepts (x, y, RGB) pixel writes over valid/ready, discards off-screen
//   pixels (counting them), converts the rest to a linear framebuffer
//   address plus reduced-depth colour, buffers them, and issues them to the
//   framebuffer port with an ack handshake, in acceptance order.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid/in_ready           upstream pixel handshake
//   in_x, in_y                  pixel coordinates
//   in_r, in_g, in_b            pixel colour, 8 bits per channel
//   fb_we/fb_ack                framebuffer write request / acceptance
//   fb_addr, fb_data            write address and packed {R,G,B} colour
//   dropped_count               saturating count of off-screen pixels
//   busy                        a pixel is buffered or being written
module pixel_writer #(
  parameter int SCREEN_W   = pixel_writer_pkg::SCREEN_W,
  parameter int SCREEN_H   = pixel_writer_pkg::SCREEN_H,
  parameter int ADDR_W     = pixel_writer_pkg::ADDR_W,
  parameter int CH_BITS    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_x,
  input  logic [7:0]             in_y,
  input  logic [7:0]             in_r,
  input  logic [7:0]             in_g,
  input  logic [7:0]             in_b,
  output logic                   fb_we,
  output logic [ADDR_W-1:0]      fb_addr,
  output logic [3*CH_BITS-1:0]   fb_data,
  input  logic                   fb_ack,
  output logic [15:0]            dropped_count,
  output logic                   busy
);

  import pixel_writer_pkg::*;

  localparam int DATA_W  = 3 * CH_BITS;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  pixel_t             w_pix;
  logic               w_fire;
  logic               w_on_screen;
  logic               w_push;
  logic               w_load;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;
  logic [ENTRY_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;

  out_state_t         r_state;
  logic               r_fb_we;
  logic [ADDR_W-1:0]  r_fb_addr;
  logic [DATA_W-1:0]  r_fb_data;
  logic [15:0]        r_dropped;

  assign w_pix = '{x: in_x, y: in_y, r: in_r, g: in_g, b: in_b};

  // NOTE: in_ready depends only on registered FIFO state, never on in_valid
  // or fb_ack, so no combinational path runs through this block; a pop in the
  // same cycle does not free a slot for a push into a full FIFO.
  assign in_ready = !w_full;
  assign w_fire   = in_valid && in_ready;

  assign w_on_screen = (32'(w_pix.x) < 32'(SCREEN_W)) &&
                       (32'(w_pix.y) < 32'(SCREEN_H));
  assign w_push      = w_fire && w_on_screen;

  // Only on-screen coordinates are enqueued, so truncation never aliases.
  assign w_addr = ADDR_W'(xy_to_addr(w_pix.x, w_pix.y, SCREEN_W));
  assign w_data = DATA_W'(pack_rgb(w_pix.r, w_pix.g, w_pix.b, CH_BITS));

  // The output register is refilled when idle, or when the current write is
  // acknowledged; this gives one write per cycle under continuous ack.
  assign w_load = !w_empty && ((r_state == OUT_IDLE) || fb_ack);

  pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_wr_data ({w_addr, w_data}),
    .i_pop     (w_load),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= OUT_IDLE;
      r_fb_we   <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
    end else begin
      case (r_state)
        OUT_IDLE: begin
          if (w_load) begin
            r_state   <= OUT_WRITE;
            r_fb_we   <= 1'b1;
            r_fb_addr <= w_head[ENTRY_W-1:DATA_W];
            r_fb_data <= w_head[DATA_W-1:0];
          end
        end
        OUT_WRITE: begin
          if (w_load) begin
            r_fb_addr <= w_head[ENTRY_W-1:DATA_W];
            r_fb_data <= w_head[DATA_W-1:0];
          end else if (fb_ack) begin
            r_state <= OUT_IDLE;
            r_fb_we <= 1'b0;
          end
        end
        default: begin
          r_state <= OUT_IDLE;
          r_fb_we <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dropped <= '0;
    end else if (w_fire && !w_on_screen && (r_dropped != 16'hFFFF)) begin
      r_dropped <= r_dropped + 16'd1;
    end
  end

  assign fb_we         = r_fb_we;
  assign fb_addr       = r_fb_addr;
  assign fb_data       = r_fb_data;
  assign dropped_count = r_dropped;
  assign busy          = !w_empty || (r_state == OUT_WRITE);

endmodule
